fu_seq: RTL and testbench
=========================

# fu_seq

Parametrised, handshaked successor to the combinational function unit in the mycpu datapath. It executes the same fs_t operation set on DW-bit operands. All results and flags are registered. FMUL runs as an iterative signed shift-add multiplier with saturation, which lets the unit close timing at wide DW. The block adds carry (c) and overflow (v) flags and sits between operand fetch and register write-back, using valid/ready on both sides.

## Interface
- DW, 16: operand/result width; legal range 4..64.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept an operation this cycle.
- a_in  in  DW  operand A.
- b_in  in  DW  operand B.
- fs_in  in  4  opcode, cast to fs_t.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes result.
- f_out  out  DW  result.
- z_out  out  1  f_out == 0.
- n_out  out  1  f_out[DW-1].
- c_out  out  1  carry/borrow/shifted-out bit.
- v_out  out  1  signed overflow or multiply saturation.

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - MUL: in_ready=0.
  - DONE: out_valid=1; in_ready=out_ready.
- Accept occurs when in_valid && in_ready. Operands and opcode are captured on the accept edge.
- Non-FMUL accept: the result and flags are computed from the captured inputs and registered; next state is DONE.
- FMUL accept setup:
  - Latch |a|, |b| as DW-bit unsigned values (|-2^(DW-1)| = 2^(DW-1) fits).
  - Latch sign = a[DW-1]^b[DW-1].
  - Clear the 2·DW accumulator and the step counter; next state is MUL.
- MUL step: each cycle, if the multiplier LSB is 1, add the multiplicand to the accumulator; then shift the multiplicand left and the multiplier right. After DW steps, go to DONE.
- FMUL final result:
  - Take signed product p = sign ? -acc : acc.
  - If p > 2^(DW-1)-1: f = 2^(DW-1)-1, v=1.
  - Else if p < -2^(DW-1): f = -2^(DW-1), v=1.
  - Else f = p[DW-1:0], v=0.
  - c=0.
- Arithmetic ops (width DW+1 for carry):
  - FADD: c = carry out; v = signed overflow.
  - FINC: as FADD with B=1.
  - FSUB: a-b; c = borrow (a<b unsigned); v = signed overflow.
  - FDEC: as FSUB with B=1.
- Shift ops, all operating on b_in:
  - FSRA: arithmetic right shift by 1; c = b[0].
  - FSHR: logical right shift by 1; c = b[0].
  - FSLA, FSHL: b<<1; c = b[DW-1].
  - v=0 for all shifts.
- FMOVA, FMOVB, FAND, FOR, FXOR, FNOT, FCLR: standard results; c=v=0.
- Undefined opcode: f=0, flags z=1, n=c=v=0.
- z_out and n_out are derived from the registered f_out. All four flags update together with f_out.
- DONE exit:
  - If out_ready and in_valid: the new accept happens this cycle (back-to-back).
  - If out_ready and no new op: go to IDLE.
  - If !out_ready: hold f_out, flags and out_valid stable.

## Timing
- Reset values: state IDLE, out_valid=0, f_out=0, z/n/c/v=0, counter=0. in_ready=1 while and after reset.
- Latency from accept edge to out_valid high:
  - Non-FMUL: 1 cycle.
  - FMUL: DW+1 cycles.
- Throughput: one non-FMUL result per cycle when out_ready is held high.
- in_valid, a_in, b_in and fs_in are ignored when in_ready=0. The unit never samples operands in MUL.
- out_valid deasserts on the cycle after the handshake unless a back-to-back accept occurred.
- Reset asserted mid-MUL aborts immediately; no out_valid follows.
- Counter width is $clog2(DW)+1; it must terminate exactly at DW steps for DW a power of two and otherwise.

## Structure
- Reused from mycpu_pkg: fs_t.
- Added to mycpu_pkg:
  - fu_state_t enum {FU_IDLE, FU_MUL, FU_DONE}.
  - fu_flags_t packed struct {z,n,c,v}.
- Sub-module: fu_seq_mul, parametrised on DW. It holds the shift-add datapath, counter, sign fix-up and saturation, with start/done pulses. fu_seq holds the FSM, single-cycle ops and output registers.

## Test plan
- FADD 0x7FFF + 0x0001, out_ready=1 → 1 cycle later: f=0x8000, n=1, v=1, c=0, z=0.
- FSUB 0x0000 - 0x0001 → f=0xFFFF, c=1, n=1, v=0. Then FMOVB b=0 back-to-back → f=0x0000, z=1 on the next cycle.
- FMUL -3 × 5 → out_valid exactly 17 cycles after accept, f=0xFFF1, n=1, v=0. in_ready=0 throughout MUL.
- FMUL 0x012C × 0x0100 → f=0x7FFF, v=1. FMUL 0x8000 × 0x0002 → f=0x8000, v=1. FMUL 0x8000 × 0xFFFF → f=0x7FFF, v=1.
- Back-pressure: hold out_ready=0 for 5 cycles after FSRA b=0x8001 → f=0xC000, c=1 held stable, in_ready=0. Release → IDLE.
- Assert rst at MUL step 8 → out_valid=0, f_out=0 immediately. After release, a new FADD 2+3 → f=0x0005.

Source files
------------

// File: rtl/mycpu_pkg.sv
// mycpu_pkg: shared types for the mycpu datapath.
//   fs_t       - 4-bit function-unit opcode (all 16 codes assigned)
//   fu_state_t - control states of the sequential function unit fu_seq
//   fu_flags_t - result flags {z, n, c, v}
package mycpu_pkg;

  typedef enum logic [3:0] {
    FMOVA = 4'd0,
    FMOVB = 4'd1,
    FINC  = 4'd2,
    FDEC  = 4'd3,
    FADD  = 4'd4,
    FSUB  = 4'd5,
    FAND  = 4'd6,
    FOR   = 4'd7,
    FXOR  = 4'd8,
    FNOT  = 4'd9,
    FSHL  = 4'd10,
    FSHR  = 4'd11,
    FSLA  = 4'd12,
    FSRA  = 4'd13,
    FMUL  = 4'd14,
    FCLR  = 4'd15
  } fs_t;

  typedef enum logic [1:0] {
    FU_IDLE = 2'd0,
    FU_MUL  = 2'd1,
    FU_DONE = 2'd2
  } fu_state_t;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } fu_flags_t;

endpackage

// File: rtl/fu_seq_mul.sv
// fu_seq_mul: iterative signed shift-add multiplier with saturation to DW bits.
//   clk, rst  - clock, async active-high reset
//   i_start   - pulse: capture |a|, |b| and the product sign, begin DW steps
//   i_a, i_b  - signed DW-bit operands (sampled only on i_start)
//   o_done    - one-cycle pulse once all DW steps have completed
//   o_f, o_v  - saturated signed result and saturation flag (valid with o_done)
module fu_seq_mul
  import mycpu_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic          o_done,
  output logic [DW-1:0] o_f,
  output logic          o_v
);

  localparam int CW = $clog2(DW) + 1;
  // Largest positive and magnitude of the most negative DW-bit signed value.
  localparam logic [2*DW-1:0] POS_LIM = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic [2*DW-1:0] NEG_LIM = {{DW{1'b0}}, 1'b1, {(DW-1){1'b0}}};

  logic [2*DW-1:0] r_acc;
  logic [2*DW-1:0] r_mcand;
  logic [DW-1:0]   r_mplier;
  logic [CW-1:0]   r_cnt;
  logic            r_sign;
  logic            r_busy;

  logic [DW-1:0]   w_mag_a;
  logic [DW-1:0]   w_mag_b;
  logic [2*DW-1:0] w_neg_acc;

  // Magnitudes as unsigned DW-bit values: |-2^(DW-1)| wraps to 2^(DW-1), which is exact.
  assign w_mag_a   = i_a[DW-1] ? (~i_a + {{(DW-1){1'b0}}, 1'b1}) : i_a;
  assign w_mag_b   = i_b[DW-1] ? (~i_b + {{(DW-1){1'b0}}, 1'b1}) : i_b;
  assign w_neg_acc = ~r_acc + {{(2*DW-1){1'b0}}, 1'b1};

  // Counter reaches DW only after the last add/shift step, so done is a single pulse.
  assign o_done = r_busy && (r_cnt == CW'(DW));

  // Shift-add datapath and step counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= {(2*DW){1'b0}};
      r_mcand  <= {(2*DW){1'b0}};
      r_mplier <= {DW{1'b0}};
      r_cnt    <= {CW{1'b0}};
      r_sign   <= 1'b0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_acc    <= {(2*DW){1'b0}};
      r_mcand  <= {{DW{1'b0}}, w_mag_a};
      r_mplier <= w_mag_b;
      r_cnt    <= {CW{1'b0}};
      r_sign   <= i_a[DW-1] ^ i_b[DW-1];
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      if (r_cnt == CW'(DW)) begin
        r_busy <= 1'b0;
      end else begin
        if (r_mplier[0]) begin
          r_acc <= r_acc + r_mcand;
        end
        r_mcand  <= {r_mcand[2*DW-2:0], 1'b0};
        r_mplier <= {1'b0, r_mplier[DW-1:1]};
        r_cnt    <= r_cnt + CW'(1);
      end
    end
  end

  // Sign fix-up and saturation; the magnitude is compared before negation.
  always_comb begin
    o_f = {DW{1'b0}};
    o_v = 1'b0;
    if (r_sign) begin
      if (r_acc > NEG_LIM) begin
        o_f = {1'b1, {(DW-1){1'b0}}};
        o_v = 1'b1;
      end else begin
        o_f = w_neg_acc[DW-1:0];
        o_v = 1'b0;
      end
    end else begin
      if (r_acc > POS_LIM) begin
        o_f = {1'b0, {(DW-1){1'b1}}};
        o_v = 1'b1;
      end else begin
        o_f = r_acc[DW-1:0];
        o_v = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fu_seq.sv
// fu_seq: handshaked function unit with registered result and z/n/c/v flags.
//   clk, rst            - clock, async active-high reset
//   in_valid/in_ready   - operation handshake; a_in, b_in, fs_in captured on accept
//   out_valid/out_ready - result handshake; f_out and flags held until taken
//   f_out               - DW-bit result
//   z_out, n_out        - zero / negative of f_out
//   c_out, v_out        - carry-borrow-shifted-out bit / signed overflow or saturation
// Single-cycle ops finish one cycle after accept; FMUL takes DW+1 cycles.
module fu_seq
  import mycpu_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  input  logic [3:0]    fs_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] f_out,
  output logic          z_out,
  output logic          n_out,
  output logic          c_out,
  output logic          v_out
);

  fu_state_t r_state;
  fu_state_t w_next;
  logic [DW-1:0] r_f;
  fu_flags_t     r_flags;

  fs_t           w_fs;
  logic          w_accept;
  logic          w_mul_start;
  logic          w_mul_done;
  logic [DW-1:0] w_mul_f;
  logic          w_mul_v;
  fu_flags_t     w_mul_flags;
  logic [DW-1:0] w_b_arith;
  logic [DW:0]   w_sum;
  logic [DW:0]   w_diff;
  logic [DW-1:0] w_f;
  logic          w_c;
  logic          w_v;
  fu_flags_t     w_flags;

  assign w_fs        = fs_t'(fs_in);
  assign w_accept    = in_valid && in_ready;
  assign w_mul_start = w_accept && (w_fs == FMUL);

  // FINC/FDEC reuse the adder/subtractor with an implicit B of 1.
  assign w_b_arith = ((w_fs == FINC) || (w_fs == FDEC)) ? {{(DW-1){1'b0}}, 1'b1} : b_in;
  assign w_sum     = {1'b0, a_in} + {1'b0, w_b_arith};
  assign w_diff    = {1'b0, a_in} - {1'b0, w_b_arith};

  fu_seq_mul #(.DW(DW)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_mul_start),
    .i_a     (a_in),
    .i_b     (b_in),
    .o_done  (w_mul_done),
    .o_f     (w_mul_f),
    .o_v     (w_mul_v)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FU_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and in_ready; DONE may accept back-to-back when the result is taken.
  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    case (r_state)
      FU_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next = (w_fs == FMUL) ? FU_MUL : FU_DONE;
        end else begin
          w_next = FU_IDLE;
        end
      end
      FU_MUL: begin
        if (w_mul_done) begin
          w_next = FU_DONE;
        end else begin
          w_next = FU_MUL;
        end
      end
      FU_DONE: begin
        in_ready = out_ready;
        if (out_ready && in_valid) begin
          w_next = (w_fs == FMUL) ? FU_MUL : FU_DONE;
        end else if (out_ready) begin
          w_next = FU_IDLE;
        end else begin
          w_next = FU_DONE;
        end
      end
      default: begin
        w_next   = FU_IDLE;
        in_ready = 1'b0;
      end
    endcase
  end

  // Single-cycle operation results.
  always_comb begin
    w_f = {DW{1'b0}};
    w_c = 1'b0;
    w_v = 1'b0;
    case (w_fs)
      FMOVA: w_f = a_in;
      FMOVB: w_f = b_in;
      FINC, FADD: begin
        w_f = w_sum[DW-1:0];
        w_c = w_sum[DW];
        w_v = (a_in[DW-1] == w_b_arith[DW-1]) && (w_sum[DW-1] != a_in[DW-1]);
      end
      FDEC, FSUB: begin
        w_f = w_diff[DW-1:0];
        w_c = w_diff[DW];
        w_v = (a_in[DW-1] != w_b_arith[DW-1]) && (w_diff[DW-1] != a_in[DW-1]);
      end
      FAND: w_f = a_in & b_in;
      FOR:  w_f = a_in | b_in;
      FXOR: w_f = a_in ^ b_in;
      FNOT: w_f = ~a_in;
      FSHL, FSLA: begin
        w_f = {b_in[DW-2:0], 1'b0};
        w_c = b_in[DW-1];
      end
      FSHR: begin
        w_f = {1'b0, b_in[DW-1:1]};
        w_c = b_in[0];
      end
      FSRA: begin
        w_f = {b_in[DW-1], b_in[DW-1:1]};
        w_c = b_in[0];
      end
      FMUL: w_f = {DW{1'b0}};
      FCLR: w_f = {DW{1'b0}};
      default: begin
        w_f = {DW{1'b0}};
        w_c = 1'b0;
        w_v = 1'b0;
      end
    endcase
  end

  // Flag packing for both result sources.
  always_comb begin
    w_flags.z     = (w_f == {DW{1'b0}});
    w_flags.n     = w_f[DW-1];
    w_flags.c     = w_c;
    w_flags.v     = w_v;
    w_mul_flags.z = (w_mul_f == {DW{1'b0}});
    w_mul_flags.n = w_mul_f[DW-1];
    w_mul_flags.c = 1'b0;
    w_mul_flags.v = w_mul_v;
  end

  // Result and flag registers; they hold while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_f     <= {DW{1'b0}};
      r_flags <= 4'b0000;
    end else if (w_accept && (w_fs != FMUL)) begin
      r_f     <= w_f;
      r_flags <= w_flags;
    end else if ((r_state == FU_MUL) && w_mul_done) begin
      r_f     <= w_mul_f;
      r_flags <= w_mul_flags;
    end
  end

  assign out_valid = (r_state == FU_DONE);
  assign f_out     = r_f;
  assign z_out     = r_flags.z;
  assign n_out     = r_flags.n;
  assign c_out     = r_flags.c;
  assign v_out     = r_flags.v;

endmodule

// File: tb/tb_fu_seq.sv
module tb_fu_seq;
  import mycpu_pkg::*;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a_in;
  logic [DW-1:0] b_in;
  logic [3:0]    fs_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] f_out;
  logic          z_out, n_out, c_out, v_out;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    fs_t         op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] f;
    logic [3:0]  fl;
  } vec_t;

  always #5 clk = ~clk;

  fu_seq #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .fs_in     (fs_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f_out     (f_out),
    .z_out     (z_out),
    .n_out     (n_out),
    .c_out     (c_out),
    .v_out     (v_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: issue an FMUL and wait (bounded) for out_valid.
  task automatic do_mul(input logic [15:0] a, input logic [15:0] b,
                        output int lat, output bit ready_bad);
    in_valid = 1'b1; fs_in = FMUL; a_in = a; b_in = b;
    step();
    in_valid = 1'b0; a_in = 16'hDEAD; b_in = 16'hBEEF; fs_in = FADD;
    lat = 0; ready_bad = 1'b0;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (in_ready !== 1'b0) ready_bad = 1'b1;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a_in = 16'h0; b_in = 16'h0; fs_in = FMOVA;
    repeat (2) step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (f_out !== 16'h0000) begin errors++; $display("FAIL reset_f: got %h want 0000", f_out); end
    checks++; if ({z_out, n_out, c_out, v_out} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {z_out, n_out, c_out, v_out}); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_add_overflow();
    in_valid = 1'b1; fs_in = FADD; a_in = 16'h7FFF; b_in = 16'h0001;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %0b want 1", out_valid); end
    checks++; if (f_out !== 16'h8000) begin errors++; $display("FAIL add_f: got %h want 8000", f_out); end
    checks++; if ({z_out, n_out, c_out, v_out} !== 4'b0101) begin errors++; $display("FAIL add_flags: got %b want 0101", {z_out, n_out, c_out, v_out}); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_valid_drop: got %0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; fs_in = FSUB; a_in = 16'h0000; b_in = 16'h0001;
    step();
    checks++; if (f_out !== 16'hFFFF) begin errors++; $display("FAIL sub_f: got %h want FFFF", f_out); end
    checks++; if ({z_out, n_out, c_out, v_out} !== 4'b0110) begin errors++; $display("FAIL sub_flags: got %b want 0110", {z_out, n_out, c_out, v_out}); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %0b want 1", in_ready); end
    fs_in = FMOVB; a_in = 16'h5555; b_in = 16'h0000;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %0b want 1", out_valid); end
    checks++; if (f_out !== 16'h0000) begin errors++; $display("FAIL movb_f: got %h want 0000", f_out); end
    checks++; if ({z_out, n_out, c_out, v_out} !== 4'b1000) begin errors++; $display("FAIL movb_flags: got %b want 1000", {z_out, n_out, c_out, v_out}); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop: got %0b want 0", out_valid); end
  endtask

  task automatic test_ops_stream();
    vec_t vecs [12];
    vecs = '{
      '{FAND,  16'hF0F0, 16'h3C3C, 16'h3030, 4'b0000},
      '{FOR,   16'hF0F0, 16'h3C3C, 16'hFCFC, 4'b0100},
      '{FXOR,  16'hF0F0, 16'h3C3C, 16'hCCCC, 4'b0100},
      '{FNOT,  16'hF0F0, 16'h0000, 16'h0F0F, 4'b0000},
      '{FMOVA, 16'h1234, 16'h9999, 16'h1234, 4'b0000},
      '{FSHL,  16'h0000, 16'h8001, 16'h0002, 4'b0010},
      '{FSHR,  16'h0000, 16'h8001, 16'h4000, 4'b0010},
      '{FSLA,  16'h0000, 16'h4000, 16'h8000, 4'b0100},
      '{FINC,  16'hFFFF, 16'h0000, 16'h0000, 4'b1010},
      '{FDEC,  16'h8000, 16'h0000, 16'h7FFF, 4'b0001},
      '{FCLR,  16'h1234, 16'h5678, 16'h0000, 4'b1000},
      '{FADD,  16'h8000, 16'h8000, 16'h0000, 4'b1011}
    };
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; fs_in = vecs[i].op; a_in = vecs[i].a; b_in = vecs[i].b;
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %0b want 1", i, out_valid); end
      checks++; if (f_out !== vecs[i].f) begin errors++; $display("FAIL stream_f[%0d]: got %h want %h", i, f_out, vecs[i].f); end
      checks++; if ({z_out, n_out, c_out, v_out} !== vecs[i].fl) begin errors++; $display("FAIL stream_flags[%0d]: got %b want %b", i, {z_out, n_out, c_out, v_out}, vecs[i].fl); end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_mul_basic();
    int lat;
    bit ready_bad;
    do_mul(16'hFFFD, 16'h0005, lat, ready_bad);
    checks++; if (lat !== 17) begin errors++; $display("FAIL mul_latency: got %0d want 17", lat); end
    checks++; if (ready_bad !== 1'b0) begin errors++; $display("FAIL mul_in_ready: got high during MUL want 0"); end
    checks++; if (f_out !== 16'hFFF1) begin errors++; $display("FAIL mul_f: got %h want FFF1", f_out); end
    checks++; if ({z_out, n_out, c_out, v_out} !== 4'b0100) begin errors++; $display("FAIL mul_flags: got %b want 0100", {z_out, n_out, c_out, v_out}); end
    step();
  endtask

  task automatic test_mul_saturate();
    int lat;
    bit ready_bad;
    logic [15:0] av [3];
    logic [15:0] bv [3];
    logic [15:0] fv [3];
    logic [3:0]  flv [3];
    av = '{16'h012C, 16'h8000, 16'h8000};
    bv = '{16'h0100, 16'h0002, 16'hFFFF};
    fv = '{16'h7FFF, 16'h8000, 16'h7FFF};
    flv = '{4'b0001, 4'b0101, 4'b0001};
    for (int i = 0; i < 3; i++) begin
      do_mul(av[i], bv[i], lat, ready_bad);
      checks++; if (lat !== 17) begin errors++; $display("FAIL sat_latency[%0d]: got %0d want 17", i, lat); end
      checks++; if (f_out !== fv[i]) begin errors++; $display("FAIL sat_f[%0d]: got %h want %h", i, f_out, fv[i]); end
      checks++; if ({z_out, n_out, c_out, v_out} !== flv[i]) begin errors++; $display("FAIL sat_flags[%0d]: got %b want %b", i, {z_out, n_out, c_out, v_out}, flv[i]); end
      step();
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; fs_in = FSRA; a_in = 16'h0000; b_in = 16'h8001;
    step();
    // A competing op is offered while stalled; it must be ignored.
    fs_in = FADD; a_in = 16'h0001; b_in = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (f_out !== 16'hC000 || {z_out, n_out, c_out, v_out} !== 4'b0110 ||
          out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall[%0d]: got f=%h fl=%b ov=%0b ir=%0b want f=C000 fl=0110 ov=1 ir=0",
                 i, f_out, {z_out, n_out, c_out, v_out}, out_valid, in_ready);
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_valid: got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %0b want 1", in_ready); end
    checks++; if (f_out !== 16'hC000) begin errors++; $display("FAIL release_f_hold: got %h want C000", f_out); end
  endtask

  task automatic test_reset_mid_mul();
    bit seen_valid;
    in_valid = 1'b1; fs_in = FMUL; a_in = 16'h0003; b_in = 16'h0005;
    step();
    in_valid = 1'b0;
    repeat (8) step();
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %0b want 0", out_valid); end
    checks++; if (f_out !== 16'h0000) begin errors++; $display("FAIL abort_f: got %h want 0000", f_out); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready: got %0b want 1", in_ready); end
    step();
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid !== 1'b0) seen_valid = 1'b1;
    end
    checks++; if (seen_valid !== 1'b0) begin errors++; $display("FAIL abort_no_result: got out_valid=1 after abort want 0"); end
    in_valid = 1'b1; fs_in = FADD; a_in = 16'h0002; b_in = 16'h0003;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL post_add_valid: got %0b want 1", out_valid); end
    checks++; if (f_out !== 16'h0005) begin errors++; $display("FAIL post_add_f: got %h want 0005", f_out); end
    checks++; if ({z_out, n_out, c_out, v_out} !== 4'b0000) begin errors++; $display("FAIL post_add_flags: got %b want 0000", {z_out, n_out, c_out, v_out}); end
    step();
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_back_to_back();
    test_ops_stream();
    test_mul_basic();
    test_mul_saturate();
    test_backpressure();
    test_reset_mid_mul();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
